// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode values on SELECT and FSM state.
package alu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_FWD  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MULT = 3'b100,
        OP_SL   = 3'b101,
        OP_SRA  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    // Shift-class opcodes run through the one-bit-per-cycle shifter.
    function automatic logic is_shift(input op_e op);
        return (op == OP_SL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per step, WIDTH steps, low WIDTH bits kept.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] product_c,
    output logic             done_c
);

    localparam int unsigned LOG_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [LOG_W-1:0] cnt_q,    cnt_d;

    // Truncated two's-complement product equals the unsigned product mod 2^WIDTH.
    assign product_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_c    = step && (cnt_q == LOG_W'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = mcand;
            mplier_d = mplier;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = product_c;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + LOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: latches a request in IDLE, runs single-cycle, iterative shift or
// shift-add multiply operations in EXEC, and publishes registered result and flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVERFLOW,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = LOG_W + 1;

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] step_val;
    logic [CNT_W-1:0] load_cnt;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_product_c;
    logic             mul_done_c;
    logic             fin;
    logic [WIDTH-1:0] fin_val;
    logic             fin_ovf;

    seq_multiplier #(.WIDTH(WIDTH)) u_mult (
        .clk       (CLK),
        .rst       (RESET),
        .load      (mul_load),
        .step      (mul_step),
        .mcand     (DATA1),
        .mplier    (DATA2),
        .product_c (mul_product_c),
        .done_c    (mul_done_c)
    );

    assign sum = acc_q + b_q;

    // One-bit shift applied per EXEC cycle to the working register.
    always_comb begin
        step_val = acc_q;
        case (op_q)
            OP_SL:   step_val = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRA:  step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            OP_ROR:  step_val = {acc_q[0], acc_q[WIDTH-1:1]};
            default: step_val = acc_q;
        endcase
    end

    // Shift distance: saturate at WIDTH for SL/SRA, modulo WIDTH for ROR.
    always_comb begin
        load_cnt = '0;
        case (op_e'(SELECT))
            OP_SL, OP_SRA: load_cnt = (DATA2 >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(DATA2);
            OP_ROR:        load_cnt = CNT_W'(DATA2[LOG_W-1:0]);
            default:       load_cnt = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        fin      = 1'b0;
        fin_val  = '0;
        fin_ovf  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_EXEC;
                    op_d     = op_e'(SELECT);
                    acc_d    = DATA1;
                    b_d      = DATA2;
                    cnt_d    = load_cnt;
                    mul_load = (op_e'(SELECT) == OP_MULT);
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_FWD: begin
                        fin     = 1'b1;
                        fin_val = b_q;
                    end
                    OP_ADD: begin
                        fin     = 1'b1;
                        fin_val = sum;
                        fin_ovf = (acc_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (sum[WIDTH-1] != acc_q[WIDTH-1]);
                    end
                    OP_AND: begin
                        fin     = 1'b1;
                        fin_val = acc_q & b_q;
                    end
                    OP_OR: begin
                        fin     = 1'b1;
                        fin_val = acc_q | b_q;
                    end
                    OP_MULT: begin
                        mul_step = 1'b1;
                        if (mul_done_c) begin
                            fin     = 1'b1;
                            fin_val = mul_product_c;
                        end
                    end
                    default: begin
                        // Zero-distance shifts still take one cycle.
                        if (cnt_q == '0) begin
                            fin     = 1'b1;
                            fin_val = acc_q;
                        end else if (cnt_q == CNT_W'(1)) begin
                            fin     = 1'b1;
                            fin_val = step_val;
                        end else begin
                            acc_d = step_val;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                endcase

                if (fin) begin
                    result_d = fin_val;
                    zero_d   = (fin_val == '0);
                    ovf_d    = fin_ovf;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FWD;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign RESULT   = result_q;
    assign ZERO     = zero_q;
    assign OVERFLOW = ovf_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed requests push expected results,
// a monitor pops and compares on every DONE pulse, including completion latency.
module tb_seq_alu;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       OVERFLOW;
    logic       BUSY;
    logic       DONE;

    seq_alu #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .SELECT   (SELECT),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .RESULT   (RESULT),
        .ZERO     (ZERO),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       o;
        int         lat;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(posedge CLK) begin
        #1;
        if (DONE) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done: got RESULT=%h at edge %0d, no request outstanding",
                         RESULT, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (RESULT === e.res && ZERO === e.z && OVERFLOW === e.o &&
                    (edge_cnt - e.start) == e.lat)
                    n_pass++;
                else
                    $display("FAIL result: got R=%h Z=%b O=%b lat=%0d, want R=%h Z=%b O=%b lat=%0d",
                             RESULT, ZERO, OVERFLOW, edge_cnt - e.start, e.res, e.z, e.o, e.lat);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    // Called at a negedge; START is high for exactly one rising edge, then inputs are scrambled.
    task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic z, input logic o, input int lat,
                         input bit expect_done);
        exp_t e;
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        if (expect_done) begin
            e.res = r; e.z = z; e.o = o; e.lat = lat; e.start = edge_cnt + 1;
            sb.push_back(e);
        end
        @(negedge CLK);
        START  = 1'b0;
        SELECT = ~sel;
        DATA1  = ~a;
        DATA2  = b ^ 8'h5A;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !DONE; i++) @(negedge CLK);
        if (!DONE) begin
            n_checks++;
            $display("FAIL timeout: DONE not seen within %0d cycles", budget);
        end
    endtask

    initial begin
        int busy_n;
        int done_n;

        RESET = 1'b1; START = 1'b0; SELECT = 3'b000; DATA1 = 8'h00; DATA2 = 8'h00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check("reset_state", {20'd0, RESULT, ZERO, OVERFLOW, BUSY, DONE}, {20'd0, 8'h00, 4'b1000});

        issue(3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1, 1'b1);   // ADD overflow
        wait_done(20);

        // MULT -3*5 with a START pulse mid-operation that must be ignored.
        issue(3'b100, 8'hFD, 8'h05, 8'hF1, 1'b0, 1'b0, 8, 1'b1);
        busy_n = 0;
        for (int i = 0; i < 20 && !DONE; i++) begin
            if (BUSY) busy_n++;
            START = (busy_n == 3);
            @(negedge CLK);
        end
        START = 1'b0;
        check("mult_busy_cycles", 32'(busy_n), 32'd8);

        issue(3'b110, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 2, 1'b1);   // SRA by 2
        wait_done(20);
        issue(3'b110, 8'h90, 8'h09, 8'hFF, 1'b0, 1'b0, 8, 1'b1);   // SRA saturated
        wait_done(20);
        issue(3'b111, 8'h01, 8'h09, 8'h80, 1'b0, 1'b0, 1, 1'b1);   // ROR 9 mod 8
        wait_done(20);
        issue(3'b101, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1, 1'b1);   // SL by 0
        wait_done(20);
        issue(3'b010, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1, 1'b1);   // AND -> zero
        wait_done(20);
        issue(3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1, 1'b1);   // OR in DONE cycle
        wait_done(20);
        issue(3'b000, 8'h12, 8'hC3, 8'hC3, 1'b0, 1'b0, 1, 1'b1);   // FWD
        wait_done(20);
        issue(3'b001, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1, 1'b1);   // ADD neg overflow
        wait_done(20);
        issue(3'b001, 8'h05, 8'hFB, 8'h00, 1'b1, 1'b0, 1, 1'b1);   // ADD wraps, no ovf
        wait_done(20);
        issue(3'b101, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3, 1'b1);   // SL by 3
        wait_done(20);
        issue(3'b111, 8'h81, 8'h04, 8'h18, 1'b0, 1'b0, 4, 1'b1);   // ROR by 4
        wait_done(20);
        issue(3'b101, 8'h55, 8'hC8, 8'h00, 1'b1, 1'b0, 8, 1'b1);   // SL saturated
        wait_done(20);
        issue(3'b100, 8'h0A, 8'h0C, 8'h78, 1'b0, 1'b0, 8, 1'b1);   // MULT 10*12
        wait_done(20);

        // Abort: MULT, stray START at iteration 2, RESET at iteration 4.
        issue(3'b100, 8'h07, 8'h09, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_state", {20'd0, RESULT, ZERO, OVERFLOW, BUSY, DONE}, {20'd0, 8'h00, 4'b1000});
        done_n = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);

        issue(3'b001, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1, 1'b1);   // recovery after reset
        wait_done(20);
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; power of two, 4..32.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  request strobe; sampled only in IDLE.
REQ-005 Port: SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MULT, 101 SL, 110 SRA, 111 ROR.
REQ-006 Port: DATA1  input  WIDTH  operand A, signed.
REQ-007 Port: DATA2  input  WIDTH  operand B, signed; shift amount (unsigned) for SL/SRA/ROR.
REQ-008 Port: RESULT  output  WIDTH  registered result, held until next completion.
REQ-009 Port: ZERO  output  1  registered, 1 when RESULT == 0.
REQ-010 Port: OVERFLOW  output  1  registered signed-overflow flag, ADD only.
REQ-011 Port: BUSY  output  1  high whenever state != IDLE.
REQ-012 Port: DONE  output  1  one-cycle pulse: RESULT/flags just updated.

Function
REQ-013 FSM states IDLE, EXEC; IDLE->EXEC on edge k where START=1; EXEC->IDLE on the completing edge.
REQ-014 At edge k SELECT, DATA1, DATA2 latched; inputs ignored thereafter until IDLE.
REQ-015 START while BUSY=1 ignored; no queuing.
REQ-016 FWD: RESULT=B; ADD: A+B mod 2^WIDTH; AND: A&B; OR: A|B; each completes at edge k+1.
REQ-017 ADD OVERFLOW = operands same sign and sum sign differs; OVERFLOW=0 for all other ops.
REQ-018 MULT: iterative shift-add, one multiplier bit per cycle, WIDTH iterations, completes at edge k+WIDTH; RESULT = low WIDTH bits of signed A*B.
REQ-019 Shifts iterate one bit per cycle; n = min(B unsigned, WIDTH) for SL/SRA, n = B mod WIDTH for ROR; completes at edge k+max(1,n).
REQ-020 SL fills zeros (B>=WIDTH gives 0); SRA fills sign bit (B>=WIDTH gives all sign); ROR rotates right, LSB to MSB.
REQ-021 On completing edge: RESULT, ZERO, OVERFLOW written, DONE=1 for following cycle, state->IDLE.
REQ-022 START may be asserted in the DONE cycle; back-to-back single-cycle ops yield one result every 2 cycles.
REQ-023 Between completions RESULT, ZERO, OVERFLOW hold; no intermediate iteration values visible on RESULT.

Reset
REQ-024 RESET=1 at an edge: state IDLE, RESULT=0, ZERO=1, OVERFLOW=0, BUSY=0, DONE=0, iteration counter and partial registers cleared.
REQ-025 RESET overrides START and aborts any operation in progress; aborted op produces no DONE.

Structure
REQ-026 Shared package alu_pkg holds opcode constants (3-bit SELECT encoding) and FSM state encoding.
REQ-027 One sub-module, seq_multiplier (iterative shift-add datapath with load/step/done), instantiated once; shifts, logic and add stay in seq_alu.

Verification (WIDTH=8)
REQ-028 START ADD A=8'h7F B=8'h01 -> edge k+1 RESULT=8'h80, OVERFLOW=1, ZERO=0, DONE one cycle.
REQ-029 START MULT A=8'hFD(-3) B=8'h05 -> RESULT=8'hF1 at edge k+8, BUSY high 8 cycles, single DONE.
REQ-030 SRA A=8'h90 B=2 -> 8'hE4 at k+2; SRA B=9 -> 8'hFF at k+8; ROR A=8'h01 B=9 -> 8'h80 at k+1; SL B=0 -> A at k+1.
REQ-031 AND A=8'hF0 B=8'h0F -> RESULT=8'h00, ZERO=1; then OR same operands started in DONE cycle -> 8'hFF, ZERO=0.
REQ-032 MULT started, START pulsed at iteration 2 (ignored), RESET at iteration 4 -> next cycle BUSY=0, RESULT=0, ZERO=1, no DONE.
